// File: rtl/alu_issue_decoder.sv
// RV32I ALU-class issue decoder: decodes an instruction word into ALU controls
// and buffers the results in a small in-order FIFO ahead of the execute stage.
module alu_issue_decoder #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [3:0]  alu_select,
  output logic        use_imm,
  output logic [31:0] imm,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        illegal,
  output logic        out_valid,
  input  logic        out_ready
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; in_ready depends only on registered occupancy, never on out_ready.

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  typedef struct packed {
    logic [3:0]  alu_select;
    logic        use_imm;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        illegal;
  } entry_t;

  entry_t          dec;
  entry_t          head;
  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push, pop;
  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [3:0]      base_op;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Operation selected by funct3 when funct7 is all zeros.
  always_comb begin
    base_op = ALU_ADD;
    case (funct3)
      3'b000:  base_op = ALU_ADD;
      3'b001:  base_op = ALU_SLL;
      3'b010:  base_op = ALU_SLT;
      3'b011:  base_op = ALU_SLTU;
      3'b100:  base_op = ALU_XOR;
      3'b101:  base_op = ALU_SRL;
      3'b110:  base_op = ALU_OR;
      default: base_op = ALU_AND;
    endcase
  end

  // Illegal encodings leave alu_select at ADD because it is only set on legal paths.
  always_comb begin
    dec     = '0;
    dec.rs1 = instr[19:15];
    dec.rs2 = instr[24:20];
    dec.rd  = instr[11:7];
    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_ZERO)                         dec.alu_select = base_op;
        else if (funct7 == F7_ALT && funct3 == 3'b000) dec.alu_select = ALU_SUB;
        else if (funct7 == F7_ALT && funct3 == 3'b101) dec.alu_select = ALU_SRA;
        else                                           dec.illegal    = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.use_imm = 1'b1;
        dec.rs2     = '0;
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          dec.imm = {27'b0, instr[24:20]};
          if (funct7 == F7_ZERO)                         dec.alu_select = base_op;
          else if (funct7 == F7_ALT && funct3 == 3'b101) dec.alu_select = ALU_SRA;
          else                                           dec.illegal    = 1'b1;
        end else begin
          dec.imm        = {{20{instr[31]}}, instr[31:20]};
          dec.alu_select = base_op;
        end
      end
      OPC_LUI: begin
        dec.use_imm = 1'b1;
        dec.rs1     = '0;
        dec.rs2     = '0;
        dec.imm     = {instr[31:12], 12'b0};
      end
      OPC_LOAD: begin
        dec.use_imm = 1'b1;
        dec.rs2     = '0;
        dec.imm     = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_STORE: begin
        dec.use_imm = 1'b1;
        dec.rd      = '0;
        dec.imm     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  assign in_ready  = (count_q < CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the buffer is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= dec;
  end

  assign head       = out_valid ? mem_q[rd_ptr_q] : '0;
  assign alu_select = head.alu_select;
  assign use_imm    = head.use_imm;
  assign imm        = head.imm;
  assign rs1        = head.rs1;
  assign rs2        = head.rs2;
  assign rd         = head.rd;
  assign illegal    = head.illegal;

endmodule

// File: tb/tb_alu_issue_decoder.sv
// Bench for alu_issue_decoder: a queue-based reference model checked every cycle,
// plus directed vectors with hand-computed expected decodes.
module tb_alu_issue_decoder;

  localparam int DEPTH = 2;
  localparam int EW    = 53;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_select;
  logic        use_imm;
  logic [31:0] imm;
  logic [4:0]  rs1, rs2, rd;
  logic        illegal;
  logic        out_valid;
  logic        out_ready;

  logic [EW-1:0] dut_vec;
  logic [EW-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            deliveries = 0;
  bit            chk_en = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  alu_issue_decoder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .in_valid(in_valid), .in_ready(in_ready),
    .alu_select(alu_select), .use_imm(use_imm), .imm(imm), .rs1(rs1), .rs2(rs2), .rd(rd),
    .illegal(illegal), .out_valid(out_valid), .out_ready(out_ready)
  );

  assign dut_vec = {alu_select, use_imm, imm, rs1, rs2, rd, illegal};

  // ---------------- reference decode ----------------
  // Record layout: {alu_select, use_imm, imm, rs1, rs2, rd, illegal}.
  function automatic logic [EW-1:0] ref_decode(input logic [31:0] w);
    logic [3:0]  sel_tab [8];
    logic [3:0]  sel;
    logic        ill, ui;
    logic [31:0] im;
    logic [4:0]  a, b, d;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    bit          is_shift;
    sel_tab = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    a = w[19:15]; b = w[24:20]; d = w[11:7];
    sel = 4'd0; ill = 1'b0; ui = 1'b0; im = 32'd0;
    is_shift = (f3 == 3'd1) || (f3 == 3'd5);
    if (op == 7'h33) begin
      if (f7 == 7'h00) sel = sel_tab[f3];
      else if (f7 == 7'h20 && f3 == 3'd0) sel = 4'd1;
      else if (f7 == 7'h20 && f3 == 3'd5) sel = 4'd7;
      else ill = 1'b1;
    end else if (op == 7'h13) begin
      ui = 1'b1; b = 5'd0;
      if (!is_shift) begin
        im = {{20{w[31]}}, w[31:20]}; sel = sel_tab[f3];
      end else begin
        im = {27'd0, w[24:20]};
        if (f7 == 7'h00) sel = sel_tab[f3];
        else if (f7 == 7'h20 && f3 == 3'd5) sel = 4'd7;
        else ill = 1'b1;
      end
    end else if (op == 7'h37) begin
      ui = 1'b1; a = 5'd0; b = 5'd0; im = {w[31:12], 12'd0};
    end else if (op == 7'h03) begin
      ui = 1'b1; b = 5'd0; im = {{20{w[31]}}, w[31:20]};
    end else if (op == 7'h23) begin
      ui = 1'b1; d = 5'd0; im = {{20{w[31]}}, w[31:25], w[11:7]};
    end else begin
      ill = 1'b1;
    end
    if (ill) sel = 4'd0;
    return {sel, ui, im, a, b, d, ill};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // ---------------- model: in-order FIFO of expected decodes ----------------
  always @(posedge clk) begin : model
    bit do_push, do_pop;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      do_push = in_valid && (exp_q.size() < DEPTH);
      do_pop  = (exp_q.size() != 0) && out_ready;
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(ref_decode(instr));
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge clk) begin : compare
    logic [EW-1:0] e;
    if (chk_en) begin
      e = (exp_q.size() != 0) ? exp_q[0] : '0;
      check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      check("in_ready", 64'(in_ready), 64'(exp_q.size() < DEPTH));
      check("head_fields", 64'(dut_vec), 64'(e));
      if (out_valid && out_ready) deliveries++;
    end
  end

  // ---------------- driver tasks ----------------
  // Called #1 after a rising edge; leaves the caller at the following negedge.
  task automatic push_one(input logic [31:0] w);
    instr = w; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic push_check(input string name, input logic [31:0] w, input logic [EW-1:0] exp);
    push_one(w);
    check({name, "_valid"}, 64'(out_valid), 64'd1);
    check(name, 64'(dut_vec), 64'(exp));
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] stream [24];
  logic [EW-1:0] snap;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = '0;
    @(posedge clk); #1 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_fields", 64'(dut_vec), 64'd0);

    // Pin the reference model against hand-decoded words.
    check("ref_sub",  64'(ref_decode(32'h40B50533)), 64'({4'd1, 1'b0, 32'h0, 5'd10, 5'd11, 5'd10, 1'b0}));
    check("ref_addi", 64'(ref_decode(32'hFFF00093)), 64'({4'd0, 1'b1, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd1, 1'b0}));
    check("ref_srai", 64'(ref_decode(32'h4030D093)), 64'({4'd7, 1'b1, 32'h3, 5'd1, 5'd0, 5'd1, 1'b0}));
    check("ref_badsh",64'(ref_decode(32'h0200D093)), 64'({4'd0, 1'b1, 32'h0, 5'd1, 5'd0, 5'd1, 1'b1}));
    check("ref_jal",  64'(ref_decode(32'h0000006F)), 64'({4'd0, 1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b1}));
    check("ref_sw",   64'(ref_decode(32'hFE512E23)), 64'({4'd0, 1'b1, 32'hFFFFFFFC, 5'd2, 5'd5, 5'd0, 1'b0}));
    check("ref_lui",  64'(ref_decode(32'h123451B7)), 64'({4'd0, 1'b1, 32'h12345000, 5'd0, 5'd0, 5'd3, 1'b0}));

    // Directed single decodes with 1-cycle latency from an empty buffer.
    @(posedge clk); #1 out_ready = 1'b1;
    push_check("dut_sub",   32'h40B50533, {4'd1, 1'b0, 32'h0, 5'd10, 5'd11, 5'd10, 1'b0});
    push_check("dut_addi",  32'hFFF00093, {4'd0, 1'b1, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd1, 1'b0});
    push_check("dut_srai",  32'h4030D093, {4'd7, 1'b1, 32'h3, 5'd1, 5'd0, 5'd1, 1'b0});
    push_check("dut_badsh", 32'h0200D093, {4'd0, 1'b1, 32'h0, 5'd1, 5'd0, 5'd1, 1'b1});
    push_check("dut_jal",   32'h0000006F, {4'd0, 1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b1});
    push_check("dut_sw",    32'hFE512E23, {4'd0, 1'b1, 32'hFFFFFFFC, 5'd2, 5'd5, 5'd0, 1'b0});
    push_check("dut_lui",   32'h123451B7, {4'd0, 1'b1, 32'h12345000, 5'd0, 5'd0, 5'd3, 1'b0});

    // Fill while stalled: third push must be refused, head stays stable.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      instr = 32'h002081B3 + (32'(i) << 7); in_valid = 1'b1;
      @(negedge clk);
      check("fill_in_ready", 64'(in_ready), (i < 2) ? 64'd1 : 64'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk); snap = dut_vec;
    check("stall_head", 64'(snap), 64'({4'd0, 1'b0, 32'h0, 5'd1, 5'd2, 5'd3, 1'b0}));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_stable", 64'(dut_vec), 64'(snap));
    end
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Steady push+pop at occupancy 1 across pointer wrap.
    out_ready = 1'b0;
    push_one(32'h00100013 | (32'd20 << 7));
    @(posedge clk); #1;
    deliveries = 0;
    for (int i = 0; i < 8; i++) begin
      instr = 32'h00100013 | (32'(i + 1) << 7); in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      check("flow_out_valid", 64'(out_valid), 64'd1);
      check("flow_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("flow_deliveries", 64'(deliveries), 64'd9);
    check("flow_empty", 64'(out_valid), 64'd0);

    // Reset with two buffered entries.
    @(posedge clk); #1 out_ready = 1'b0;
    push_one(32'h0020F1B3);
    @(posedge clk); #1;
    push_one(32'h0020E1B3);
    @(posedge clk); #1;
    rst_n = 1'b0; in_valid = 1'b1; instr = 32'h40B50533;
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; deliveries = 0;
    @(negedge clk);
    check("rst_mid_valid", 64'(out_valid), 64'd0);
    check("rst_mid_fields", 64'(dut_vec), 64'd0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_mid_no_stale", 64'(deliveries), 64'd0);

    // Mixed stream with random back-pressure and held valid until accepted.
    stream = '{32'h002081B3, 32'h002091B3, 32'h0020A1B3, 32'h0020B1B3, 32'h0020C1B3,
               32'h0020D1B3, 32'h4020D1B3, 32'h0020E1B3, 32'h0020F1B3, 32'h0220F1B3,
               32'h402091B3, 32'h0050A193, 32'h0050B193, 32'h8000C193, 32'h0050E193,
               32'h0050F193, 32'h00509193, 32'h40509193, 32'h0050D193, 32'hFFC12283,
               32'h00208463, 32'h800002B7, 32'h80A12023, 32'hFFF00093};
    @(posedge clk); #1;
    for (int i = 0; i < 24; i++) begin
      bit acc;
      int guard;
      guard = 0;
      instr = stream[i]; in_valid = 1'b1;
      do begin
        @(negedge clk); acc = in_ready;
        @(posedge clk); #1;
        out_ready = 1'($urandom_range(0, 1));
        guard++;
      end while (!acc && guard < 50);
      if (!acc) check("accept_timeout", 64'(guard), 64'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (DEPTH + 2) @(posedge clk);
    @(negedge clk);
    check("stream_drained", 64'(exp_q.size()), 64'd0);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
